// File: rtl/sweep_pkg.sv
// Shared types and constants for the sweep capture block.
// The optional per-point peak field exists only when SWEEP_CAPTURE_PEAK_EN is defined.
package sweep_pkg;

  localparam int DAC_W   = 12;
  localparam int SUM_W   = 24;
  localparam int COUNT_W = 13;

  localparam logic [SUM_W-1:0]   SUM_MAX   = '1;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACCUM = 2'd2
  } state_t;

  // One record per sweep point, as stored in the FIFO and presented at the head.
  typedef struct packed {
    logic [DAC_W-1:0]   index;
    logic [SUM_W-1:0]   sum;
    logic [COUNT_W-1:0] count;
`ifdef SWEEP_CAPTURE_PEAK_EN
    logic [DAC_W-1:0]   peak;
`endif
  } record_t;

  // Add a sample to the running sum, clamping at the all-ones value.
  function automatic logic [SUM_W-1:0] sum_sat_add(input logic [SUM_W-1:0] sum,
                                                   input logic [DAC_W-1:0] sample);
    logic [SUM_W:0] wide;
    wide = {1'b0, sum} + (SUM_W+1)'(sample);
    return wide[SUM_W] ? SUM_MAX : wide[SUM_W-1:0];
  endfunction

  // Increment the sample count, holding at the all-ones value.
  function automatic logic [COUNT_W-1:0] count_sat_inc(input logic [COUNT_W-1:0] count);
    return (count == COUNT_MAX) ? COUNT_MAX : count + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/sweep_capture_fifo.sv
// Single-clock record FIFO for sweep_capture.
// Registered write, registered full/empty flags, head read straight from storage.
// A write while full is accepted only if a read happens in the same cycle.
module sweep_capture_fifo
  import sweep_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    i_stepCLK,
  input  logic    i_reset,
  input  logic    wr_en,
  input  record_t wr_data,
  input  logic    rd_en,
  output record_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  record_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    used;
  logic [AW:0]    used_nxt;
  logic           do_wr;
  logic           do_rd;

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign head  = mem[rd_ptr];

  // Occupancy after this cycle's read and write.
  always_comb begin
    used_nxt = used;
    if (do_wr && !do_rd) begin
      used_nxt = used + (AW+1)'(1);
    end else if (do_rd && !do_wr) begin
      used_nxt = used - (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge i_stepCLK) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge i_stepCLK) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      used  <= used_nxt;
      empty <= (used_nxt == '0);
      full  <= (used_nxt == (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/sweep_capture.sv
// sweep_capture: per-point ADC accumulation for a DAC sweep, one record per point
// queued into a small FIFO for readout.
// Optional feature macro: SWEEP_CAPTURE_PEAK_EN (per-point maximum on o_peak).
//
// Output handshake: o_valid is high whenever the FIFO holds a record and the head
// fields are meaningful only then; the head record is consumed on any cycle where
// o_valid and i_ready are both high, and the head holds steady otherwise.
module sweep_capture
  import sweep_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                i_stepCLK,
  input  logic                i_reset,
  input  logic                i_arm,
  input  logic [DAC_W-1:0]    i_steps,
  input  logic                i_stepping,
  input  logic [DAC_W-1:0]    i_sample,
  input  logic                i_sample_valid,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [DAC_W-1:0]    o_index,
  output logic [SUM_W-1:0]    o_sum,
  output logic [COUNT_W-1:0]  o_count,
  output logic [DAC_W-1:0]    o_peak,
  output logic                o_busy,
  output logic                o_overflow,
  output state_t              dbg_state
);

  state_t               state_q;
  state_t               state_d;
  logic [DAC_W-1:0]     idx_q;
  logic [DAC_W-1:0]     last_idx_q;
  logic [SUM_W-1:0]     sum_q;
  logic [COUNT_W-1:0]   count_q;
  logic                 overflow_q;
`ifdef SWEEP_CAPTURE_PEAK_EN
  logic [DAC_W-1:0]     peak_q;
`endif

  logic     start_point;   // boundary pulse opens a point (seed accumulator)
  logic     close_point;   // boundary pulse closes the open point (push record)
  logic     accumulate;    // in-point valid sample
  logic     last_point;
  logic     pop;
  logic     fifo_full;
  logic     fifo_empty;
  record_t  rec_in;
  record_t  head;

  assign last_point = (idx_q == last_idx_q);
  assign pop        = o_valid && i_ready;

  // FSM state register.
  always_ff @(posedge i_stepCLK) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: arm restarts from any state and wins over stepping.
  always_comb begin
    state_d = state_q;
    if (i_arm) begin
      state_d = WAIT;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        WAIT:    if (i_stepping) state_d = ACCUM;
        ACCUM:   if (i_stepping && last_point) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: datapath strobes and busy.
  always_comb begin
    start_point = 1'b0;
    close_point = 1'b0;
    accumulate  = 1'b0;
    o_busy      = (state_q != IDLE);
    if (!i_arm) begin
      case (state_q)
        WAIT: begin
          start_point = i_stepping;
        end
        ACCUM: begin
          close_point = i_stepping;
          start_point = i_stepping && !last_point;
          accumulate  = !i_stepping && i_sample_valid;
        end
        default: begin
        end
      endcase
    end
  end

  // Index, frame length and overflow bookkeeping.
  always_ff @(posedge i_stepCLK) begin
    if (i_reset) begin
      idx_q      <= '0;
      last_idx_q <= '0;
      overflow_q <= 1'b0;
    end else if (i_arm) begin
      idx_q      <= '0;
      last_idx_q <= i_steps;
      overflow_q <= 1'b0;
    end else if (close_point) begin
      // The index advances even when the record is dropped, leaving a visible gap.
      idx_q <= idx_q + DAC_W'(1);
      if (fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Sum and count accumulator; the boundary sample seeds the new point.
  always_ff @(posedge i_stepCLK) begin
    if (i_reset || i_arm) begin
      sum_q   <= '0;
      count_q <= '0;
    end else if (start_point) begin
      sum_q   <= i_sample_valid ? SUM_W'(i_sample) : '0;
      count_q <= i_sample_valid ? COUNT_W'(1) : '0;
    end else if (accumulate) begin
      sum_q   <= sum_sat_add(sum_q, i_sample);
      count_q <= count_sat_inc(count_q);
    end
  end

`ifdef SWEEP_CAPTURE_PEAK_EN
  // Per-point maximum, restarted and seeded alongside the accumulator.
  always_ff @(posedge i_stepCLK) begin
    if (i_reset || i_arm) begin
      peak_q <= '0;
    end else if (start_point) begin
      peak_q <= i_sample_valid ? i_sample : '0;
    end else if (accumulate && (i_sample > peak_q)) begin
      peak_q <= i_sample;
    end
  end
`endif

  // Record assembled from the point being closed.
  always_comb begin
    rec_in       = '0;
    rec_in.index = idx_q;
    rec_in.sum   = sum_q;
    rec_in.count = count_q;
`ifdef SWEEP_CAPTURE_PEAK_EN
    rec_in.peak  = peak_q;
`endif
  end

  sweep_capture_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_stepCLK (i_stepCLK),
    .i_reset   (i_reset),
    .wr_en     (close_point),
    .wr_data   (rec_in),
    .rd_en     (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign o_valid    = !fifo_empty;
  assign o_overflow = overflow_q;
  assign dbg_state  = state_q;

  // Head fields read as zero whenever nothing is queued.
  assign o_index = fifo_empty ? '0 : head.index;
  assign o_sum   = fifo_empty ? '0 : head.sum;
  assign o_count = fifo_empty ? '0 : head.count;
`ifdef SWEEP_CAPTURE_PEAK_EN
  assign o_peak  = fifo_empty ? '0 : head.peak;
`else
  assign o_peak  = '0;
`endif

endmodule

// File: tb/tb_sweep_capture.sv
// Testbench for sweep_capture: directed scenarios plus randomized frames, checked
// by a scoreboard fed from a point-level reference model.
module tb_sweep_capture;
  import sweep_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = 61;   // {index 12, sum 24, count 13, peak 12}
`ifdef SWEEP_CAPTURE_PEAK_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_arm = 1'b0;
  logic [11:0]  i_steps = '0;
  logic         i_stepping = 1'b0;
  logic [11:0]  i_sample = '0;
  logic         i_sample_valid = 1'b0;
  logic         i_ready = 1'b0;
  logic         o_valid;
  logic [11:0]  o_index;
  logic [23:0]  o_sum;
  logic [12:0]  o_count;
  logic [11:0]  o_peak;
  logic         o_busy;
  logic         o_overflow;
  state_t       dbg_state;

  always #5 clk = ~clk;

  sweep_capture #(.DEPTH(DEPTH)) dut (
    .i_stepCLK      (clk),
    .i_reset        (i_reset),
    .i_arm          (i_arm),
    .i_steps        (i_steps),
    .i_stepping     (i_stepping),
    .i_sample       (i_sample),
    .i_sample_valid (i_sample_valid),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_index        (o_index),
    .o_sum          (o_sum),
    .o_count        (o_count),
    .o_peak         (o_peak),
    .o_busy         (o_busy),
    .o_overflow     (o_overflow),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] exp_q[$];
  bit           mon_en  = 1'b0;
  int           rdy_mode = 0;   // 0: ready low, 1: ready high, 2: random

  // Reference model: a frame is a list of points, each point a bag of samples.
  bit           m_active = 1'b0;
  bit           m_open   = 1'b0;
  bit           m_ovf    = 1'b0;
  int           m_idx    = 0;
  int           m_last   = 0;
  int           m_n      = 0;
  int           m_peak   = 0;
  int           m_occ    = 0;
  longint       m_sum    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_begin_point(input bit vld, input int smp);
    m_open = 1'b1;
    m_sum  = vld ? longint'(smp) : 0;
    m_n    = vld ? 1 : 0;
    m_peak = vld ? smp : 0;
  endfunction

  // One clock of the model, evaluated from the inputs about to be clocked in.
  task automatic model_step();
    bit           pop;
    bit           pushed;
    logic [11:0]  ei;
    logic [23:0]  es;
    logic [12:0]  ec;
    logic [11:0]  ep;
    if (i_reset) begin
      exp_q.delete();
      m_occ = 0; m_active = 0; m_open = 0; m_ovf = 0;
      return;
    end
    pop    = i_ready && (m_occ > 0);
    pushed = 1'b0;
    if (i_arm) begin
      m_active = 1; m_open = 0; m_last = int'(i_steps); m_idx = 0; m_ovf = 0;
    end else if (m_active && i_stepping) begin
      if (m_open) begin
        ei = 12'(m_idx);
        es = (m_sum > longint'(24'hFFFFFF)) ? 24'hFFFFFF : 24'(m_sum);
        ec = (m_n > 8191) ? 13'h1FFF : 13'(m_n);
        ep = PEAK_EN ? 12'(m_peak) : 12'h000;
        if (m_occ == DEPTH && !pop) begin
          m_ovf = 1'b1;
        end else begin
          exp_q.push_back({ei, es, ec, ep});
          pushed = 1'b1;
        end
        if (m_idx == m_last) begin
          m_active = 0; m_open = 0;
        end else begin
          m_idx++;
          m_begin_point(i_sample_valid, int'(i_sample));
        end
      end else begin
        m_begin_point(i_sample_valid, int'(i_sample));
      end
    end else if (m_active && m_open && i_sample_valid) begin
      m_sum += longint'(i_sample);
      m_n++;
      if (int'(i_sample) > m_peak) m_peak = int'(i_sample);
    end
    m_occ = m_occ + (pushed ? 1 : 0) - (pop ? 1 : 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      model_step();
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (mon_en) begin
      check("o_valid", 64'(o_valid), 64'(exp_q.size() != 0));
      check("o_busy", 64'(o_busy), 64'(m_active));
      check("o_overflow", 64'(o_overflow), 64'(m_ovf));
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_record: got idx 0x%0h expected none at %0t", o_index, $time);
        end else begin
          e = exp_q.pop_front();
          check("o_index", 64'(o_index), 64'(e[60:49]));
          check("o_sum",   64'(o_sum),   64'(e[48:25]));
          check("o_count", 64'(o_count), 64'(e[24:12]));
          check("o_peak",  64'(o_peak),  64'(e[11:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit arm, input logic [11:0] steps, input bit stp,
                       input logic [11:0] smp, input bit vld);
    @(posedge clk);
    #1;
    i_reset        = 1'b0;
    i_arm          = arm;
    i_steps        = steps;
    i_stepping     = stp;
    i_sample       = smp;
    i_sample_valid = vld;
    i_ready        = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 12'd0, 0, 12'd0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      i_reset    = 1'b1;
      i_arm      = 1'b1;   // reset must win over arm
      i_stepping = 1'b1;
      i_steps    = 12'd3;
    end
  endtask

  // A point opened by a stepping pulse on its first cycle, then len-1 plain cycles.
  task automatic point_seq(input int len, input int vld_pct, input int lo, input int hi,
                           input int arm_pct);
    bit a;
    for (int i = 0; i < len; i++) begin
      a = (arm_pct > 0) && ($urandom_range(0, 99) < arm_pct);
      drive(a, 12'($urandom_range(0, 5)), (i == 0),
            12'($urandom_range(lo, hi)), ($urandom_range(0, 99) < vld_pct));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nsteps;
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b0;
    check("reset_o_valid",    64'(o_valid),    64'd0);
    check("reset_o_busy",     64'(o_busy),     64'd0);
    check("reset_o_overflow", 64'(o_overflow), 64'd0);
    check("reset_o_index",    64'(o_index),    64'd0);
    check("reset_o_sum",      64'(o_sum),      64'd0);
    check("reset_o_count",    64'(o_count),    64'd0);
    check("reset_o_peak",     64'(o_peak),     64'd0);
    mon_en = 1'b1;

    // Basic frame: 3 points of 10,20,30,40.
    rdy_mode = 1;
    drive(1, 12'd2, 0, 12'd0, 0);
    for (int p = 0; p < 3; p++) begin
      drive(0, 12'd0, 1, 12'd10, 1);
      drive(0, 12'd0, 0, 12'd20, 1);
      drive(0, 12'd0, 0, 12'd30, 1);
      drive(0, 12'd0, 0, 12'd40, 1);
    end
    drive(0, 12'd0, 1, 12'd77, 1);
    idle(4);

    // Peak: samples 5, 900, 3 in one point.
    drive(1, 12'd0, 0, 12'd0, 0);
    drive(0, 12'd0, 1, 12'd5, 1);
    drive(0, 12'd0, 0, 12'd900, 1);
    drive(0, 12'd0, 0, 12'd3, 1);
    drive(0, 12'd0, 1, 12'd0, 0);
    idle(3);

    // Saturation: 5000 x 0xFFF, then a 9000-sample count run.
    drive(1, 12'd0, 0, 12'd0, 0);
    point_seq(5000, 100, 4095, 4095, 0);
    drive(0, 12'd0, 1, 12'd0, 0);
    drive(1, 12'd0, 0, 12'd0, 0);
    point_seq(9000, 100, 0, 15, 0);
    drive(0, 12'd0, 1, 12'd0, 0);
    idle(3);

    // Backpressure: 6 points with the consumer stalled, then drain.
    rdy_mode = 0;
    drive(1, 12'd5, 0, 12'd0, 0);
    for (int p = 0; p < 6; p++) point_seq(3, 80, 0, 4095, 0);
    drive(0, 12'd0, 1, 12'd0, 0);
    idle(3);
    rdy_mode = 1;
    idle(8);

    // Push and pop together while full: ready rises on the closing cycle only.
    rdy_mode = 0;
    drive(1, 12'd4, 0, 12'd0, 0);
    for (int p = 0; p < 5; p++) point_seq(3, 80, 0, 4095, 0);
    rdy_mode = 1;
    drive(0, 12'd0, 1, 12'd0, 0);
    idle(8);

    // Mid-frame re-arm (arm together with stepping), then reset mid-frame.
    drive(1, 12'd3, 0, 12'd0, 0);
    for (int p = 0; p < 3; p++) point_seq(3, 100, 0, 4095, 0);
    drive(1, 12'd1, 1, 12'd55, 1);
    for (int p = 0; p < 2; p++) point_seq(4, 100, 0, 4095, 0);
    drive(0, 12'd0, 1, 12'd0, 0);
    idle(2);
    rdy_mode = 0;
    drive(1, 12'd3, 0, 12'd0, 0);
    for (int p = 0; p < 3; p++) point_seq(2, 100, 0, 4095, 0);
    do_reset(2);
    idle(3);

    // Randomized frames with random backpressure and occasional re-arm.
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      nsteps = $urandom_range(0, 6);
      drive(1, 12'(nsteps), 0, 12'd0, 0);
      idle($urandom_range(0, 2));
      for (int p = 0; p <= nsteps; p++)
        point_seq($urandom_range(1, 6), 70, 0, 4095, 2);
      drive(0, 12'd0, 1, 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 3));
    end

    // Drain what is left, bounded.
    rdy_mode = 1;
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) idle(1);
    idle(2);
    check("drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
